chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving the bits added per cycle; WIDTH mod CHUNK != 0 or CHUNK < 1 SHALL be an elaboration error; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a, b, cin present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: addend A.
REQ-008 The block SHALL have port b, input, WIDTH bits: addend B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: sum and cout valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 In IDLE, the block SHALL hold in_ready=1 and out_valid=0.
REQ-016 In IDLE, on a clock edge with in_valid=1, the block SHALL capture a, b, cin, clear chunk index i to 0, and go to BUSY.
REQ-017 In BUSY, each edge SHALL add a[i*CHUNK+:CHUNK] + b[i*CHUNK+:CHUNK] + carry (carry = captured cin for i=0), write the CHUNK-bit result into sum[i*CHUNK+:CHUNK], register the chunk carry-out as carry, and increment i.
REQ-018 On the edge processing i = N-1, the block SHALL drive the final carry to cout and go to DONE.
REQ-019 In DONE, the block SHALL hold out_valid=1 with sum and cout stable.
REQ-020 In DONE, on an edge with out_ready=1, the block SHALL go to IDLE.
REQ-021 The block SHALL drive in_ready=0 in BUSY and DONE; in_valid SHALL be ignored there, with no overlap or queuing.
REQ-022 After the acceptance edge, out_valid SHALL rise exactly N edges later.
REQ-023 With out_ready held at 1, the block SHALL accept a new transaction every N+2 cycles.
REQ-024 The a, b and cin inputs SHALL NOT affect the result once captured; changes after acceptance SHALL be ignored.
REQ-025 sum and cout SHALL be meaningful only while out_valid=1; they SHALL hold their last values through IDLE and update only chunk-by-chunk in BUSY.
REQ-026 For N=1 (CHUNK=WIDTH), the block SHALL spend one BUSY cycle and raise out_valid 1 edge after acceptance.
REQ-027 The block SHALL contain no combinational path from in_valid or out_ready to any output.

Reset
REQ-028 When rst=1, the block SHALL immediately, without waiting for clk, set state=IDLE, i=0, carry=0, sum=0, cout=0, out_valid=0, in_ready=1.
REQ-029 A reset asserted in BUSY or DONE SHALL abandon the transaction without producing a result.
REQ-030 The first edge after rst deasserts SHALL be able to accept a transaction.

Verification (WIDTH=32, CHUNK=8, N=4 unless stated)
REQ-031 The bench SHALL drive a=0, b=0, cin=0 accepted at edge k -> out_valid=1 after edge k+4, sum=0x00000000, cout=0.
REQ-032 The bench SHALL drive a=0xFFFFFFFF, b=0x00000001, cin=0, with carry rippling through all chunks -> sum=0x00000000, cout=1.
REQ-033 The bench SHALL drive a=0x000000FF, b=0, cin=1, with carry crossing a chunk boundary -> sum=0x00000100, cout=0; a=0x7FFFFFFF, b=0x7FFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=0.
REQ-034 The bench SHALL hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum and cout stable, in_ready=0, no acceptance; then out_ready=1 -> IDLE next edge and new operands accepted on the following edge.
REQ-035 The bench SHALL assert rst mid-clock after 2 BUSY edges -> out_valid=0, in_ready=1, sum=0 immediately; a subsequent 0x12345678+0x11111111+0 -> sum=0x23456789, cout=0.
REQ-036 The bench SHALL use a WIDTH=4, CHUNK=4 instance with a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1, out_valid 1 edge after acceptance; all 8 single-bit-slice combinations of a[0], b[0], cin SHALL match the full-adder truth table.

Source files
------------

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder.
// The master drives operands and out_ready. The slave (the adder) returns
// in_ready, out_valid, sum and cout.
interface chunked_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder that adds WIDTH-bit operands CHUNK bits per clock.
// The carry ripples from chunk to chunk through a register.
// A transaction is captured in IDLE and processed over N BUSY cycles.
// The result is then held in DONE until the consumer takes it.
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    chunked_adder_if.slave   bus
);
    localparam int N  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("chunked_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_ratio
        $error("chunked_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IW-1:0]    i_q,         i_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CHUNK:0]   chunk_res_s;

    // Handshake flags come straight from flops, so in_valid and out_ready
    // have no combinational route to any output.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    // Next-state, chunk arithmetic and registered-output decode.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        chunk_res_s = {(CHUNK+1){1'b0}};

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    i_d     = {IW{1'b0}};
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                chunk_res_s = {1'b0, a_q[i_q*CHUNK +: CHUNK]}
                            + {1'b0, b_q[i_q*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, carry_q};
                sum_d[i_q*CHUNK +: CHUNK] = chunk_res_s[CHUNK-1:0];
                carry_d = chunk_res_s[CHUNK];
                i_d     = i_q + IW'(1);
                if (i_q == IW'(N-1)) begin
                    cout_d  = chunk_res_s[CHUNK];
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= {IW{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder.
// It drives a 32/8 instance (N=4) and a 4/4 instance (N=1).
module tb_chunked_adder;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    chunked_adder_if #(.WIDTH(32)) big ();
    chunked_adder_if #(.WIDTH(4))  sml ();

    chunked_adder #(.WIDTH(32), .CHUNK(8)) u_big (.clk(clk), .rst(rst), .bus(big));
    chunked_adder #(.WIDTH(4),  .CHUNK(4)) u_sml (.clk(clk), .rst(rst), .bus(sml));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand set and scramble the inputs after acceptance.
    // Count the edges until out_valid rises, with a bound.
    // Pulse out_ready to return to IDLE.
    task automatic run_big(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                           output int lat, output logic [31:0] s, output logic c);
        big.a = va; big.b = vb; big.cin = vc; big.in_valid = 1'b1;
        @(posedge clk); #1;
        big.in_valid = 1'b0; big.a = ~va; big.b = ~vb; big.cin = ~vc;
        lat = 0;
        while (big.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = big.sum; c = big.cout;
        big.out_ready = 1'b1;
        @(posedge clk); #1;
        big.out_ready = 1'b0;
    endtask

    task automatic run_sml(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                           output int lat, output logic [3:0] s, output logic c);
        sml.a = va; sml.b = vb; sml.cin = vc; sml.in_valid = 1'b1;
        @(posedge clk); #1;
        sml.in_valid = 1'b0; sml.a = ~va; sml.b = ~vb; sml.cin = ~vc;
        lat = 0;
        while (sml.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sml.sum; c = sml.cout;
        sml.out_ready = 1'b1;
        @(posedge clk); #1;
        sml.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        tests++; if (big.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", big.in_ready); end
        tests++; if (big.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", big.out_valid); end
        tests++; if (big.sum !== 32'h00000000) begin fails++; $display("FAIL reset_sum: got %h expected 00000000", big.sum); end
        tests++; if (big.cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b expected 0", big.cout); end
        tests++; if (sml.in_ready !== 1'b1) begin fails++; $display("FAIL reset_sml_in_ready: got %b expected 1", sml.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // The first edge after reset release must accept the transaction.
    task automatic test_zero();
        int lat; logic [31:0] s; logic c;
        run_big(32'h00000000, 32'h00000000, 1'b0, lat, s, c);
        tests++; if (lat !== 4) begin fails++; $display("FAIL zero_latency: got %0d expected 4", lat); end
        tests++; if (s !== 32'h00000000) begin fails++; $display("FAIL zero_sum: got %h expected 00000000", s); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL zero_cout: got %b expected 0", c); end
        tests++; if (big.in_ready !== 1'b1) begin fails++; $display("FAIL zero_back_idle: got %b expected 1", big.in_ready); end
    endtask

    task automatic test_ripple();
        int lat; logic [31:0] s; logic c;
        run_big(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, s, c);
        tests++; if (s !== 32'h00000000) begin fails++; $display("FAIL ripple_sum: got %h expected 00000000", s); end
        tests++; if (c !== 1'b1) begin fails++; $display("FAIL ripple_cout: got %b expected 1", c); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL ripple_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] s; logic c;
        big.a = 32'h01010101; big.b = 32'h01010101; big.cin = 1'b0; big.in_valid = 1'b1;
        @(posedge clk); #1;
        big.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (big.sum !== 32'h00000202) begin fails++; $display("FAIL mid_partial_sum: got %h expected 00000202", big.sum); end
        tests++; if (big.cout !== 1'b1) begin fails++; $display("FAIL mid_cout_held: got %b expected 1", big.cout); end
        tests++; if (big.in_ready !== 1'b0) begin fails++; $display("FAIL mid_busy_in_ready: got %b expected 0", big.in_ready); end
        #3 rst = 1'b1;
        #1;
        tests++; if (big.out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out_valid: got %b expected 0", big.out_valid); end
        tests++; if (big.in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready: got %b expected 1", big.in_ready); end
        tests++; if (big.sum !== 32'h00000000) begin fails++; $display("FAIL mid_rst_sum: got %h expected 00000000", big.sum); end
        tests++; if (big.cout !== 1'b0) begin fails++; $display("FAIL mid_rst_cout: got %b expected 0", big.cout); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_big(32'h12345678, 32'h11111111, 1'b0, lat, s, c);
        tests++; if (s !== 32'h23456789) begin fails++; $display("FAIL mid_after_sum: got %h expected 23456789", s); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL mid_after_cout: got %b expected 0", c); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL mid_after_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_boundary();
        int lat; logic [31:0] s; logic c;
        run_big(32'h000000FF, 32'h00000000, 1'b1, lat, s, c);
        tests++; if (s !== 32'h00000100) begin fails++; $display("FAIL boundary_sum: got %h expected 00000100", s); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL boundary_cout: got %b expected 0", c); end
        run_big(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, lat, s, c);
        tests++; if (s !== 32'hFFFFFFFF) begin fails++; $display("FAIL half_sum: got %h expected FFFFFFFF", s); end
        tests++; if (c !== 1'b0) begin fails++; $display("FAIL half_cout: got %b expected 0", c); end
    endtask

    // Hold the result in DONE while new operands are offered.
    task automatic test_done_hold();
        int lat;
        big.a = 32'h80000000; big.b = 32'h80000000; big.cin = 1'b1; big.in_valid = 1'b1;
        @(posedge clk); #1;
        big.in_valid = 1'b0;
        lat = 0;
        while (big.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL hold_latency: got %0d expected 4", lat); end
        big.a = 32'h00000005; big.b = 32'h00000006; big.cin = 1'b0; big.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests++; if (big.out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid[%0d]: got %b expected 1", k, big.out_valid); end
            tests++; if (big.in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", k, big.in_ready); end
            tests++; if (big.sum !== 32'h00000001) begin fails++; $display("FAIL hold_sum[%0d]: got %h expected 00000001", k, big.sum); end
            tests++; if (big.cout !== 1'b1) begin fails++; $display("FAIL hold_cout[%0d]: got %b expected 1", k, big.cout); end
        end
        big.out_ready = 1'b1;
        @(posedge clk); #1;
        big.out_ready = 1'b0;
        tests++; if (big.out_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid: got %b expected 0", big.out_valid); end
        tests++; if (big.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %b expected 1", big.in_ready); end
        @(posedge clk); #1;
        tests++; if (big.in_ready !== 1'b0) begin fails++; $display("FAIL hold_new_accept: got %b expected 0", big.in_ready); end
        big.in_valid = 1'b0;
        lat = 0;
        while (big.out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        tests++; if (lat !== 4) begin fails++; $display("FAIL hold_new_latency: got %0d expected 4", lat); end
        tests++; if (big.sum !== 32'h0000000B) begin fails++; $display("FAIL hold_new_sum: got %h expected 0000000b", big.sum); end
        tests++; if (big.cout !== 1'b0) begin fails++; $display("FAIL hold_new_cout: got %b expected 0", big.cout); end
        big.out_ready = 1'b1;
        @(posedge clk); #1;
        big.out_ready = 1'b0;
    endtask

    // With both sides always willing, acceptances are N+2 = 6 edges apart.
    task automatic test_back_to_back();
        int acc[$];
        int guard;
        logic pre;
        big.a = 32'h00000001; big.b = 32'h00000002; big.cin = 1'b0;
        big.in_valid = 1'b1; big.out_ready = 1'b1;
        for (int e = 0; e < 20; e++) begin
            pre = big.in_ready;
            @(posedge clk); #1;
            if (pre) acc.push_back(e);
        end
        big.in_valid = 1'b0;
        tests++; if (acc.size() < 3) begin fails++; $display("FAIL b2b_count: got %0d expected at least 3", acc.size()); end
        else begin
            tests++; if (acc[1] - acc[0] != 6) begin fails++; $display("FAIL b2b_period0: got %0d expected 6", acc[1] - acc[0]); end
            tests++; if (acc[2] - acc[1] != 6) begin fails++; $display("FAIL b2b_period1: got %0d expected 6", acc[2] - acc[1]); end
        end
        guard = 0;
        while (!(big.in_ready === 1'b1 && big.out_valid === 1'b0) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        tests++; if (big.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain: got %b expected 1", big.in_ready); end
        big.out_ready = 1'b0;
    endtask

    // Single-chunk instance: one BUSY cycle, then the full-adder truth table.
    task automatic test_n1();
        int lat; logic [3:0] s; logic c;
        logic [7:0] exp_s;
        logic [7:0] exp_co;
        exp_s  = 8'b10010110;
        exp_co = 8'b11101000;
        run_sml(4'hF, 4'hF, 1'b1, lat, s, c);
        tests++; if (s !== 4'hF) begin fails++; $display("FAIL n1_sum: got %h expected f", s); end
        tests++; if (c !== 1'b1) begin fails++; $display("FAIL n1_cout: got %b expected 1", c); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL n1_latency: got %0d expected 1", lat); end
        for (int k = 0; k < 8; k++) begin
            logic ka, kb, kc;
            ka = k[2]; kb = k[1]; kc = k[0];
            run_sml({3'b000, ka}, {3'b000, kb}, kc, lat, s, c);
            tests++; if (s[0] !== exp_s[k]) begin fails++; $display("FAIL fa_sum[%0d]: got %b expected %b", k, s[0], exp_s[k]); end
            tests++; if (s[1] !== exp_co[k]) begin fails++; $display("FAIL fa_carry[%0d]: got %b expected %b", k, s[1], exp_co[k]); end
            tests++; if (lat !== 1) begin fails++; $display("FAIL fa_latency[%0d]: got %0d expected 1", k, lat); end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0;
        big.in_valid = 1'b0; big.a = 32'h0; big.b = 32'h0; big.cin = 1'b0; big.out_ready = 1'b0;
        sml.in_valid = 1'b0; sml.a = 4'h0;  sml.b = 4'h0;  sml.cin = 1'b0; sml.out_ready = 1'b0;
        test_reset();
        test_zero();
        test_ripple();
        test_reset_mid();
        test_boundary();
        test_done_hold();
        test_back_to_back();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
